// File: rtl/misr_pipe_pkg.sv
// Shared types and helpers for the MISR-checked lane pipeline.
// Mode encoding, default polynomial and output-width helper.
package misr_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_SUM = 2'd0,
        MODE_XOR = 2'd1,
        MODE_MAX = 2'd2,
        MODE_MIN = 2'd3
    } mode_e;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

    // Result width: wide enough to hold an exact sum of all lanes.
    function automatic int ow_of(input int width, input int lanes);
        return width + $clog2(lanes);
    endfunction

endpackage

// File: rtl/misr_pipe_reduce.sv
// Combinational lane reducer: sign-extends every lane to OW bits
// and folds them by sum, xor, signed max or signed min.
module misr_pipe_reduce
    import misr_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    localparam int OW = ow_of(WIDTH, LANES)
) (
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [1:0]             mode,
    output logic [OW-1:0]          res
);

    logic [OW-1:0] lane_x [LANES];
    logic [OW-1:0] acc;

    // Sign-extend each lane to the result width.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_x[i] = {{(OW-WIDTH){in_data[i*WIDTH+WIDTH-1]}},
                         in_data[i*WIDTH +: WIDTH]};
        end
    end

    // Fold lanes; strict compares keep the lowest index on ties.
    always_comb begin
        acc = lane_x[0];
        unique case (mode_e'(mode))
            MODE_SUM: begin
                for (int i = 1; i < LANES; i++)
                    acc = acc + lane_x[i];
            end
            MODE_XOR: begin
                for (int i = 1; i < LANES; i++)
                    acc = acc ^ lane_x[i];
            end
            MODE_MAX: begin
                for (int i = 1; i < LANES; i++)
                    if ($signed(lane_x[i]) > $signed(acc))
                        acc = lane_x[i];
            end
            MODE_MIN: begin
                for (int i = 1; i < LANES; i++)
                    if ($signed(lane_x[i]) < $signed(acc))
                        acc = lane_x[i];
            end
        endcase
        res = acc;
    end

endmodule

// File: rtl/misr_pipe_top.sv
// Multi-lane reduce pipeline with global-stall flow control and
// a MISR signature plus beat count over every delivered result.
module misr_pipe_top
    import misr_pipe_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               LANES    = 4,
    parameter int               DEPTH    = 3,
    parameter int               SIG_W    = 32,
    parameter logic [31:0]      POLY     = DEFAULT_POLY,
    parameter logic [SIG_W-1:0] SIG_SEED = '0,
    localparam int              OW       = ow_of(WIDTH, LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OW-1:0]          out_data,
    input  logic                   sig_clr,
    output logic [SIG_W-1:0]       sig,
    output logic [31:0]            sig_count
);

    localparam logic [SIG_W-1:0] POLY_W = POLY[SIG_W-1:0];

    logic [DEPTH-1:0]         vld_q, vld_d;
    logic [DEPTH-1:0][OW-1:0] dat_q, dat_d;
    logic [SIG_W-1:0]         sig_q, sig_d;
    logic [31:0]              cnt_q, cnt_d;

    logic          stall;
    logic          accept;
    logic          fire;
    logic [OW-1:0] red;

    misr_pipe_reduce #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_reduce (
        .in_data (in_data),
        .mode    (in_mode),
        .res     (red)
    );

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign sig       = sig_q;
    assign sig_count = cnt_q;

    // Shift every stage (bubbles included) unless the output stalls.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (!stall) begin
            vld_d[0] = accept;
            if (accept)
                dat_d[0] = red;
            for (int i = 1; i < DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
                dat_d[i] = dat_q[i-1];
            end
        end
    end

    // Fold each delivered word; a clear overrides the fold.
    always_comb begin
        sig_d = sig_q;
        cnt_d = cnt_q;
        if (sig_clr) begin
            sig_d = SIG_SEED;
            cnt_d = '0;
        end else if (fire) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY_W : '0)
                  ^ SIG_W'(out_data);
            cnt_d = cnt_q + 32'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
            sig_q <= SIG_SEED;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            sig_q <= sig_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
